// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, MIPS R-type funct values and the funct decoder
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_NOR = 6'h27;

    typedef struct packed {
        logic       bad;
        logic [3:0] ctrl;
    } dec_t;

    // Unsupported functs decode to AND with bad set; bad entries never reach the ALU.
    function automatic dec_t decode_funct(input logic [5:0] funct);
        dec_t d;
        d.bad  = 1'b0;
        d.ctrl = ALU_AND;
        case (funct)
            FUNCT_AND: d.ctrl = ALU_AND;
            FUNCT_OR:  d.ctrl = ALU_OR;
            FUNCT_ADD: d.ctrl = ALU_ADD;
            FUNCT_SUB: d.ctrl = ALU_SUB;
            FUNCT_SLT: d.ctrl = ALU_SLT;
            FUNCT_NOR: d.ctrl = ALU_NOR;
            default:   d.bad  = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// rtl/alu_dispatch_if.sv - op input, ALU drive/return and result handshake bundle
interface alu_dispatch_if #(parameter int TAG_W = 4);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [5:0]       in_funct;
    logic [TAG_W-1:0] in_tag;

    logic [31:0]      alu_src1;
    logic [31:0]      alu_src2;
    logic [3:0]       alu_control;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_cout;
    logic             alu_overflow;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [2:0]       res_zcv;
    logic [TAG_W-1:0] res_tag;
    logic             illegal;

    modport slave (
        input  in_valid, in_src1, in_src2, in_funct, in_tag,
        output in_ready,
        output alu_src1, alu_src2, alu_control,
        input  alu_result, alu_zero, alu_cout, alu_overflow,
        output res_valid, res_data, res_zcv, res_tag, illegal,
        input  res_ready
    );

    modport master (
        output in_valid, in_src1, in_src2, in_funct, in_tag,
        input  in_ready,
        input  alu_src1, alu_src2, alu_control,
        output alu_result, alu_zero, alu_cout, alu_overflow,
        input  res_valid, res_data, res_zcv, res_tag, illegal,
        output res_ready
    );

endinterface

// File: rtl/alu_dispatch_fifo.sv
// rtl/alu_dispatch_fifo.sv - generic synchronous FIFO with wrap-bit pointers and head peek
module alu_dispatch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointers roll over modulo 2*DEPTH; the extra MSB tells full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - R-type issue stage feeding the alu, with result register; ALU_DISPATCH_STATS_EN adds issue/overflow counters
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    alu_dispatch_if.slave bus
`ifdef ALU_DISPATCH_STATS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_ovf
`endif
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      src1;
        logic [31:0]      src2;
        dec_t             dec;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t           in_entry;
    entry_t           head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             slot_free;
    logic             issue;
    logic             drop;

    logic             res_valid_q;
    logic [31:0]      res_data_q;
    logic [2:0]       res_zcv_q;
    logic [TAG_W-1:0] res_tag_q;
    logic             illegal_q;

    always_comb begin
        in_entry      = '0;
        in_entry.tag  = bus.in_tag;
        in_entry.src1 = bus.in_src1;
        in_entry.src2 = bus.in_src2;
        in_entry.dec  = decode_funct(bus.in_funct);
    end

    assign bus.in_ready = rst_n && !full;
    assign push         = bus.in_valid && bus.in_ready;

    alu_dispatch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_entry),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // A bad head is discarded without waiting for the result slot.
    assign slot_free = !res_valid_q || bus.res_ready;
    assign issue     = !empty && !head.dec.bad && slot_free;
    assign drop      = !empty && head.dec.bad;
    assign pop       = issue || drop;

    always_comb begin
        bus.alu_src1    = '0;
        bus.alu_src2    = '0;
        bus.alu_control = '0;
        if (!empty && !head.dec.bad) begin
            bus.alu_src1    = head.src1;
            bus.alu_src2    = head.src2;
            bus.alu_control = head.dec.ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zcv_q   <= '0;
            res_tag_q   <= '0;
            illegal_q   <= 1'b0;
        end else begin
            illegal_q <= drop;
            if (issue) begin
                res_valid_q <= 1'b1;
                res_data_q  <= bus.alu_result;
                res_zcv_q   <= {bus.alu_zero, bus.alu_cout, bus.alu_overflow};
                res_tag_q   <= head.tag;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zcv   = res_zcv_q;
    assign bus.res_tag   = res_tag_q;
    assign bus.illegal   = illegal_q;

`ifdef ALU_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_ovf    <= '0;
        end else if (issue) begin
            if (stat_issued != 16'hFFFF) begin
                stat_issued <= stat_issued + 16'd1;
            end
            if (bus.alu_overflow && (stat_ovf != 16'hFFFF)) begin
                stat_ovf <= stat_ovf + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - randomized scoreboard bench for alu_dispatch; covers ALU_DISPATCH_STATS_EN when defined
module tb_alu_dispatch;

    localparam int TW = 4;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    alu_dispatch_if #(.TAG_W(TW)) bus ();

`ifdef ALU_DISPATCH_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_ovf;
`endif

    alu_dispatch #(.DEPTH(4), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_DISPATCH_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_ovf    (stat_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational alu, keyed by control code.
    always_comb begin
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (bus.alu_control)
            4'd0:  r = bus.alu_src1 & bus.alu_src2;
            4'd1:  r = bus.alu_src1 | bus.alu_src2;
            4'd2:  begin
                w = {1'b0, bus.alu_src1} + {1'b0, bus.alu_src2};
                r = w[31:0]; c = w[32];
                v = (bus.alu_src1[31] == bus.alu_src2[31]) && (r[31] != bus.alu_src1[31]);
            end
            4'd6:  begin
                w = {1'b0, bus.alu_src1} + {1'b0, ~bus.alu_src2} + 33'd1;
                r = w[31:0]; c = w[32];
                v = (bus.alu_src1[31] != bus.alu_src2[31]) && (r[31] != bus.alu_src1[31]);
            end
            4'd7:  r = {31'd0, $signed(bus.alu_src1) < $signed(bus.alu_src2)};
            4'd12: r = ~(bus.alu_src1 | bus.alu_src2);
            default: r = '0;
        endcase
        bus.alu_result   = r;
        bus.alu_zero     = (r == 32'd0);
        bus.alu_cout     = c;
        bus.alu_overflow = v;
    end

    typedef struct packed {
        logic        ok;
        logic [2:0]  zcv;
        logic [31:0] d;
    } ref_t;

    typedef struct {
        logic [31:0]   d;
        logic [2:0]    zcv;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t         exp_q[$];
    int           ill_exp;
    logic [5:0]   legal_f [6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};

    logic          acc, took, ill;
    logic [31:0]   g_data;
    logic [2:0]    g_zcv;
    logic [TW-1:0] g_tag;

    // Reference result straight from the R-type semantics, using wide integer arithmetic.
    function automatic ref_t ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ref_t   o;
        longint sa, sb, s;
        longint ua, ub;
        logic   c, v;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
        c = 1'b0; v = 1'b0; o = '0; o.ok = 1'b1;
        case (f)
            6'h24: o.d = a & b;
            6'h25: o.d = a | b;
            6'h20: begin s = sa + sb; o.d = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF;
                         v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'h22: begin s = sa - sb; o.d = 32'(ua - ub); c = (ua >= ub);
                         v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'h2A: o.d = (sa < sb) ? 32'd1 : 32'd0;
            6'h27: o.d = ~(a | b);
            default: o.ok = 1'b0;
        endcase
        o.zcv = {o.d == 32'd0, c, v};
        return o;
    endfunction

    task automatic model_push(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
        ref_t r;
        exp_t e;
        r = ref_op(f, a, b);
        if (r.ok) begin
            e.d = r.d; e.zcv = r.zcv; e.tag = t;
            exp_q.push_back(e);
        end else begin
            ill_exp++;
        end
    endtask

    // One clock: drive at posedge+1, sample handshakes before the edge, outputs at posedge+1.
    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] f, input logic [TW-1:0] t, input logic r);
        bus.in_valid = v; bus.in_src1 = a; bus.in_src2 = b;
        bus.in_funct = f; bus.in_tag = t; bus.res_ready = r;
        #3;
        acc    = v && bus.in_ready;
        took   = bus.res_valid && r;
        g_data = bus.res_data; g_zcv = bus.res_zcv; g_tag = bus.res_tag;
        @(posedge clk); #1;
        ill = bus.illegal;
        if (acc) model_push(f, a, b, t);
    endtask

    task automatic idle(input logic r);
        cyc(1'b0, '0, '0, '0, '0, r);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(1'b0); idle(1'b0);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", bus.res_valid); end
        total++; if (bus.res_data !== 32'd0) begin bad++; $display("FAIL reset_res_data got=%h want=0", bus.res_data); end
        total++; if (bus.res_zcv !== 3'd0 || bus.res_tag !== '0) begin bad++; $display("FAIL reset_zcv_tag got=%b/%h want=0/0", bus.res_zcv, bus.res_tag); end
        total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", bus.illegal); end
        total++; if (bus.alu_control !== 4'd0 || bus.alu_src1 !== 32'd0) begin bad++; $display("FAIL reset_alu_drive got=%h/%h want=0/0", bus.alu_control, bus.alu_src1); end
        rst_n = 1'b1;
        idle(1'b0);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_add;
        exp_q = {};
        cyc(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 6'h20, 4'h5, 1'b0);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL add_accept got=%b want=1", acc); end
        total++; if (bus.alu_control !== 4'd2) begin bad++; $display("FAIL add_alu_control got=%0d want=2", bus.alu_control); end
        total++; if (bus.alu_src1 !== 32'h7FFF_FFFF || bus.alu_src2 !== 32'h1) begin bad++; $display("FAIL add_alu_src got=%h/%h want=7fffffff/1", bus.alu_src1, bus.alu_src2); end
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b want=0", bus.res_valid); end
        idle(1'b0);
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", bus.res_valid); end
        total++; if (bus.res_data !== 32'h8000_0000) begin bad++; $display("FAIL add_data got=%h want=80000000", bus.res_data); end
        total++; if (bus.res_zcv !== 3'b001) begin bad++; $display("FAIL add_zcv got=%b want=001", bus.res_zcv); end
        total++; if (bus.res_tag !== 4'h5) begin bad++; $display("FAIL add_tag got=%h want=5", bus.res_tag); end
        idle(1'b1);
        total++; if (took !== 1'b1 || bus.res_valid !== 1'b0) begin bad++; $display("FAIL add_consume got=%b/%b want=1/0", took, bus.res_valid); end
        exp_q = {};
    endtask

    task automatic test_stream;
        logic [31:0] a [3]    = '{32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] b [3]    = '{32'h0FF0_0FF0, 32'h0000_0001, 32'h0};
        logic [5:0]  f [3]    = '{6'h24, 6'h2A, 6'h27};
        logic [31:0] want [3] = '{32'h00F0_00F0, 32'h0000_0001, 32'hFFFF_FFFF};
        int n = 0, first = -1, last = -1;
        exp_q = {};
        for (int i = 0; i < 8; i++) begin
            if (i < 3) cyc(1'b1, a[i], b[i], f[i], TW'(i), 1'b1);
            else idle(1'b1);
            if (took) begin
                if (n < 3) begin
                    total++; if (g_data !== want[n] || g_tag !== TW'(n)) begin bad++; $display("FAIL stream_result%0d got=%h/%h want=%h/%h", n, g_data, g_tag, want[n], n); end
                end
                if (first < 0) first = i;
                last = i; n++;
            end
        end
        total++; if (n != 3) begin bad++; $display("FAIL stream_count got=%0d want=3", n); end
        total++; if (first != 2 || last != 4) begin bad++; $display("FAIL stream_timing got=%0d..%0d want=2..4", first, last); end
        exp_q = {};
    endtask

    task automatic test_backpressure;
        int acc_n = 0, n = 0;
        logic [31:0]   hold_d;
        logic [TW-1:0] hold_t;
        exp_q = {};
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, $urandom, $urandom, legal_f[$urandom_range(0, 5)], TW'(i + 1), 1'b0);
            if (acc) acc_n++;
        end
        total++; if (acc_n != 5) begin bad++; $display("FAIL bp_accepted got=%0d want=5", acc_n); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
        hold_d = bus.res_data; hold_t = bus.res_tag;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            total++; if (bus.res_valid !== 1'b1 || bus.res_data !== hold_d || bus.res_tag !== hold_t) begin bad++; $display("FAIL bp_stable got=%b/%h/%h want=1/%h/%h", bus.res_valid, bus.res_data, bus.res_tag, hold_d, hold_t); end
        end
        for (int i = 0; i < 12; i++) begin
            idle(1'b1);
            if (took) begin
                n++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra got=%h want=none", g_data); end
                else begin
                    if (g_data !== exp_q[0].d || g_zcv !== exp_q[0].zcv || g_tag !== exp_q[0].tag) begin bad++; $display("FAIL bp_result got=%h/%b/%h want=%h/%b/%h", g_data, g_zcv, g_tag, exp_q[0].d, exp_q[0].zcv, exp_q[0].tag); end
                    void'(exp_q.pop_front());
                end
            end
        end
        total++; if (n != 5 || exp_q.size() != 0) begin bad++; $display("FAIL bp_drain got=%0d left=%0d want=5 left=0", n, exp_q.size()); end
    endtask

    task automatic test_illegal;
        int ill_seen = 0, n = 0;
        exp_q = {}; ill_exp = 0;
        cyc(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 6'h00, 4'h9, 1'b1);
        total++; if (bus.alu_src1 !== 32'd0 || bus.alu_control !== 4'd0) begin bad++; $display("FAIL ill_alu_zero got=%h/%h want=0/0", bus.alu_src1, bus.alu_control); end
        cyc(1'b1, 32'd5, 32'd5, 6'h22, 4'hA, 1'b1);
        if (ill) ill_seen++;
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            if (ill) ill_seen++;
            if (took) begin
                n++;
                total++; if (g_data !== 32'd0 || g_zcv[2] !== 1'b1 || g_tag !== 4'hA) begin bad++; $display("FAIL ill_sub_result got=%h/%b/%h want=0/1xx/a", g_data, g_zcv, g_tag); end
            end
        end
        total++; if (ill_seen != 1) begin bad++; $display("FAIL ill_pulses got=%0d want=1", ill_seen); end
        total++; if (n != 1) begin bad++; $display("FAIL ill_results got=%0d want=1", n); end
        exp_q = {};
    endtask

    task automatic test_reset_mid;
        int n = 0;
        exp_q = {};
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, $urandom, legal_f[$urandom_range(0, 5)], TW'(i + 3), 1'b0);
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%b want=1", bus.res_valid); end
        rst_n = 1'b0;
        idle(1'b0);
        total++; if (bus.res_valid !== 1'b0 || bus.res_data !== 32'd0) begin bad++; $display("FAIL rm_res got=%b/%h want=0/0", bus.res_valid, bus.res_data); end
        total++; if (bus.res_zcv !== 3'd0 || bus.res_tag !== '0 || bus.illegal !== 1'b0) begin bad++; $display("FAIL rm_flags got=%b/%h/%b want=0/0/0", bus.res_zcv, bus.res_tag, bus.illegal); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rm_in_ready got=%b want=0", bus.in_ready); end
        rst_n = 1'b1;
        exp_q = {};
        idle(1'b0);
        total++; if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin bad++; $display("FAIL rm_flushed got=%b/%b want=1/0", bus.in_ready, bus.res_valid); end
        cyc(1'b1, 32'd100, 32'd23, 6'h22, 4'hC, 1'b1);
        cyc(1'b1, 32'h0000_FF00, 32'h0F0F_0F0F, 6'h25, 4'hD, 1'b1);
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            if (took) begin
                n++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL rm_extra got=%h want=none", g_data); end
                else begin
                    if (g_data !== exp_q[0].d || g_zcv !== exp_q[0].zcv || g_tag !== exp_q[0].tag) begin bad++; $display("FAIL rm_result got=%h/%b/%h want=%h/%b/%h", g_data, g_zcv, g_tag, exp_q[0].d, exp_q[0].zcv, exp_q[0].tag); end
                    void'(exp_q.pop_front());
                end
            end
        end
        total++; if (n != 2) begin bad++; $display("FAIL rm_count got=%0d want=2", n); end
    endtask

    task automatic test_random;
        int            ill_seen = 0;
        logic          v, r, stall;
        logic [5:0]    f;
        logic [31:0]   hold_d;
        logic [TW-1:0] hold_t;
        exp_q = {}; ill_exp = 0;
        for (int i = 0; i < 440; i++) begin
            v = (i < 400) && ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : legal_f[$urandom_range(0, 5)];
            r = (i >= 400) || ($urandom_range(0, 2) != 0);
            stall  = bus.res_valid && !r;
            hold_d = bus.res_data; hold_t = bus.res_tag;
            cyc(v, $urandom, ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom, f, TW'($urandom), r);
            if (ill) ill_seen++;
            if (took) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_extra got=%h want=none", g_data); end
                else begin
                    if (g_data !== exp_q[0].d || g_zcv !== exp_q[0].zcv || g_tag !== exp_q[0].tag) begin bad++; $display("FAIL rnd_result got=%h/%b/%h want=%h/%b/%h", g_data, g_zcv, g_tag, exp_q[0].d, exp_q[0].zcv, exp_q[0].tag); end
                    void'(exp_q.pop_front());
                end
            end
            if (stall) begin
                total++; if (bus.res_valid !== 1'b1 || bus.res_data !== hold_d || bus.res_tag !== hold_t) begin bad++; $display("FAIL rnd_stall got=%b/%h/%h want=1/%h/%h", bus.res_valid, bus.res_data, bus.res_tag, hold_d, hold_t); end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_lost got=%0d want=0", exp_q.size()); end
        total++; if (ill_seen != ill_exp) begin bad++; $display("FAIL rnd_illegal got=%0d want=%0d", ill_seen, ill_exp); end
    endtask

`ifdef ALU_DISPATCH_STATS_EN
    task automatic test_stats;
        rst_n = 1'b0; idle(1'b1);
        rst_n = 1'b1; idle(1'b1);
        total++; if (stat_issued !== 16'd0 || stat_ovf !== 16'd0) begin bad++; $display("FAIL stats_reset got=%0d/%0d want=0/0", stat_issued, stat_ovf); end
        cyc(1'b1, 32'h7FFF_FFFF, 32'h1, 6'h20, 4'h1, 1'b1);
        cyc(1'b1, 32'd1, 32'd2, 6'h20, 4'h2, 1'b1);
        cyc(1'b1, 32'd3, 32'd4, 6'h20, 4'h3, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        total++; if (stat_issued !== 16'd3) begin bad++; $display("FAIL stats_issued got=%0d want=3", stat_issued); end
        total++; if (stat_ovf !== 16'd1) begin bad++; $display("FAIL stats_ovf got=%0d want=1", stat_ovf); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_src1 = '0; bus.in_src2 = '0;
        bus.in_funct = '0; bus.in_tag = '0; bus.res_ready = 1'b0;
        ill_exp = 0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_stream();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
`ifdef ALU_DISPATCH_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Issue stage that sits directly upstream of the team's `alu`. It is followed by a result register that sits downstream of the ALU.
- Accepts R-type ops (src1, src2, MIPS funct, tag) over a valid/ready handshake and buffers them in a small FIFO.
- Decodes funct into the 4-bit ALU_control and drives the combinational `alu` from the FIFO head.
- Captures the ALU result and flags into a registered output with a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- TAG_W, 4, width of the opaque tag passed from input to result.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  op offered.
- in_ready  out  1  op accepted when in_valid && in_ready.
- in_src1  in  32  operand 1.
- in_src2  in  32  operand 2.
- in_funct  in  6  MIPS funct field.
- in_tag  in  TAG_W  opaque tag.
- alu_src1  out  32  to alu.src1.
- alu_src2  out  32  to alu.src2.
- alu_control  out  4  to alu.ALU_control.
- alu_result  in  32  from alu.result.
- alu_zero  in  1  from alu.zero.
- alu_cout  in  1  from alu.cout.
- alu_overflow  in  1  from alu.overflow.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  32  captured result.
- res_zcv  out  3  captured {zero, cout, overflow}.
- res_tag  out  TAG_W  tag of the captured op.
- illegal  out  1  one-cycle pulse: an illegal funct was discarded.

Behaviour:
- Funct decode is done on push and stored per entry as a 4-bit code plus a bad bit:
  - 0x24 -> 0 (AND)
  - 0x25 -> 1 (OR)
  - 0x20 -> 2 (ADD)
  - 0x22 -> 6 (SUB)
  - 0x2A -> 7 (SLT)
  - 0x27 -> 12 (NOR)
  - any other funct -> bad = 1
- FIFO:
  - wr_ptr and rd_ptr are log2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = pointers equal; full = low bits equal and MSBs differ.
  - Pointers wrap modulo 2*DEPTH.
- in_ready = rst_n && !full. There is no bypass, so a push while full cannot happen.
- ALU drive:
  - alu_src1, alu_src2 and alu_control come combinationally from the head entry.
  - When empty, or when the head is bad, they are driven to all zeros.
- Issue condition: !empty && !head.bad && (!res_valid || res_ready).
- On issue, at the clock edge:
  - pop the head;
  - res_data <= alu_result;
  - res_zcv <= {alu_zero, alu_cout, alu_overflow};
  - res_tag <= head tag;
  - res_valid <= 1.
- Latency: push at edge N makes the entry the head. If the FIFO was empty and the result slot is free, the result is valid after edge N+1. Throughput is 1 op/cycle.
- Result slot:
  - res_valid && res_ready with no issue in the same cycle -> res_valid <= 0.
  - Issue and consume in the same cycle -> the new result replaces the old one, and res_valid stays 1.
  - While res_valid && !res_ready, res_data, res_zcv and res_tag are held stable.
- Bad head: popped at the next edge regardless of the result slot. illegal is high for exactly that one cycle and no result is produced.
- Simultaneous push and pop in the same cycle are both honoured; count is unchanged.
- Reset, including mid-operation:
  - pointers cleared, so the FIFO content is discarded;
  - res_valid = 0, res_data = 0, res_zcv = 0, res_tag = 0, illegal = 0;
  - in_ready is low while rst_n = 0.
- Ops must never be reordered.

Optional Feature:
- ALU_DISPATCH_STATS_EN defined:
  - adds outputs stat_issued[15:0] and stat_ovf[15:0];
  - stat_issued increments on every issue;
  - stat_ovf increments on every issue with alu_overflow = 1;
  - both saturate at 0xFFFF and clear on reset.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package alu_pkg holds:
  - ALU_AND=4'd0, ALU_OR=4'd1, ALU_ADD=4'd2, ALU_SUB=4'd6, ALU_SLT=4'd7, ALU_NOR=4'd12;
  - FUNCT_* constants;
  - the decode function.
- Sub-module alu_dispatch_fifo: a generic synchronous FIFO (WIDTH, DEPTH) exposing push, pop, full, empty and head data.
- alu_dispatch itself contains the decode, issue logic and result register.

Test Plan:
- ADD: src1 = 0x7FFFFFFF, src2 = 0x00000001, funct 0x20 -> alu_control = 2; res_data = 0x80000000; res_zcv = 001; tag echoed; res_valid one cycle after push.
- Stream: AND 0xF0F0F0F0 & 0x0FF00FF0, then SLT 0xFFFFFFFF vs 0x00000001, then NOR 0 / 0, with res_ready = 1 -> results 0x00F000F0, 0x00000001, 0xFFFFFFFF in order on back-to-back cycles.
- Backpressure: DEPTH = 4, res_ready = 0, push 6 ops -> exactly 5 accepted, in_ready low. Then assert res_ready -> all 5 results in order with no drops or duplicates, and res_data stable while stalled.
- Illegal funct: push funct 0x00 then SUB 5 - 5 -> illegal pulses for one cycle, no result for the 0x00 op, then res_data = 0 with res_zcv[2] = 1.
- Reset mid-stream: 3 ops queued and res_valid = 1, drive rst_n low for one edge -> all outputs return to reset values; ops pushed after reset produce correct results.
- With ALU_DISPATCH_STATS_EN: 3 ADDs including 0x7FFFFFFF + 1 -> stat_issued = 3, stat_ovf = 1.
